usbfs_host_transaction: RTL and testbench
=========================================

Name: usbfs_host_transaction

Overview:
- Host-side transaction initiator; mirror of the device transaction layer, for host-mode and device-core loopback benches.
- Takes one command (SETUP/OUT/IN to addr/endp), emits token (+DATAx) through the packet-level TX interface, then waits for the reply on the packet-level RX interface and reports a result.
- For IN, forwards payload bytes and returns ACK.
- Sits between a host controller/sequencer and usbfs_packet_tx/usbfs_packet_rx.

Parameters:
MAXPKT, 64, max payload bytes per DATA packet; cmd_len clamped to this
TIMEOUT_CYCLES, 1000, clk cycles from end of own packet to reply deadline
IPG_CYCLES, 16, idle cycles between end of own packet and next tp_sta

Ports:
clk  in  1  60MHz clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_type  in  2  0=OUT,1=IN,2=SETUP
cmd_addr  in  7  device address
cmd_endp  in  4  endpoint number
cmd_len  in  10  OUT/SETUP payload bytes (0 allowed)
cmd_toggle  in  1  0=DATA0,1=DATA1 for OUT/SETUP
buf_addr  out  10  payload buffer read address
buf_data  in  8  buffer data, 1-cycle read latency
rd_data  out  8  IN payload byte
rd_valid  out  1  1-cycle strobe per IN payload byte
res_valid  out  1  1-cycle result strobe
res_code  out  3  0=ACK,1=NAK,2=STALL,3=TIMEOUT,4=ERR,5=DATA_OK
res_len  out  10  IN payload bytes received
res_toggle  out  1  toggle of received DATAx
tp_sta  out  1  packet start pulse
tp_pid  out  4  PID, held from tp_sta to tp_done
tp_byte_req  in  1  request next byte
tp_byte  out  8  requested byte
tp_fin_n  out  1  1=tp_byte valid, 0=no more bytes
tp_done  in  1  pulse when EOP of own packet driven
rp_pid  in  4  received PID
rp_byte_en  in  1  received byte strobe (payload then 2 CRC16 bytes)
rp_byte  in  8  received byte
rp_fin  in  1  end of received packet
rp_okay  in  1  valid with rp_fin: PID/CRC/stuffing ok

Behaviour:
- Reset (sync, dominant, mid-operation included): state IDLE; all outputs 0 except cmd_ready=1; no tp_sta after reset; buf_addr=0.
- PIDs:
  - OUT=0001, IN=1001, SETUP=1101
  - DATA0=0011, DATA1=1011
  - ACK=0010, NAK=1010, STALL=1110
- Accept on cmd_valid&cmd_ready: latch fields; len=min(cmd_len,MAXPKT).
- States: IDLE, TOK, GAP, DATA, WAIT_HS, WAIT_DATA, GAP_ACK, ACK, REPORT.
- TOK:
  - pulse tp_sta with token PID.
  - Bytes: byte0={endp[0],addr[6:0]}, byte1={crc[0],crc[1],crc[2],crc[3],crc[4],endp[3:1]}, then tp_fin_n=0.
  - CRC5: poly x^5+x^2+1, init 5'h1F, over the 11 bits addr[0] first, result inverted.
- tp_byte/tp_fin_n valid within 2 cycles of tp_byte_req and held until the next req. Packet TX appends CRC16 only for DATAx PIDs.
- After tp_done:
  - OUT/SETUP: GAP (IPG_CYCLES), then DATA.
  - IN: WAIT_DATA.
- DATA:
  - tp_pid=DATA0/1 per toggle; SETUP forces DATA0.
  - Bytes streamed from buffer addresses 0..len-1, prefetched so each req is served in time; tp_fin_n=0 after len bytes; len=0 gives immediate tp_fin_n=0.
  - After tp_done goes to WAIT_HS.
- Timeout counter: cleared at tp_done, counts in WAIT_*; reaching TIMEOUT_CYCLES gives TIMEOUT. An rp_fin arriving on the same cycle as the deadline wins.
- WAIT_HS, on rp_fin:
  - !rp_okay gives ERR.
  - ACK, NAK or STALL PID gives that code.
  - Any other PID gives ERR.
- WAIT_DATA, on rp_fin:
  - NAK/STALL gives that code.
  - DATAx with rp_okay: GAP_ACK (IPG_CYCLES), then ACK handshake packet (no bytes, tp_fin_n=0 on first req), then DATA_OK with res_toggle=pid[3].
  - !rp_okay or other PID gives ERR, no ACK sent.
- IN payload path:
  - 2-byte delay line; a byte is forwarded on rd_valid only when a 3rd byte arrives, so the 2 CRC16 bytes are never emitted.
  - Bytes beyond MAXPKT are dropped and the result becomes ERR.
  - res_len counts forwarded bytes.
  - On ERR the consumer discards already-forwarded bytes.
- Received bytes/rp_fin outside WAIT_* states are ignored.
- REPORT: res_valid pulses 1 cycle; res_* held until next res_valid; next cycle IDLE.
- cmd_valid while busy is ignored (not queued).

Test Plan:
- OUT addr=0x15 endp=0xE len=0 → tp_pid=0001, bytes 0x15,0xEF then tp_fin_n=0; DATA0 with 0 bytes; device ACK → res_code=0.
- SETUP addr=0 endp=0 len=8, cmd_toggle=1 → DATA0 (forced), buf_addr 0..7 bytes sent in order; NAK reply → res_code=1.
- IN with device DATA1 of 4 payload + 2 CRC bytes, rp_okay=1 → rd_valid ×4 (CRC not forwarded); ACK sent ≥16 cycles after rp_fin; res_code=5, res_len=4, res_toggle=1.
- IN with no reply → res_code=3 exactly TIMEOUT_CYCLES after tp_done; rp_fin coinciding with the deadline → that reply reported instead.
- IN DATA0 with rp_okay=0 → no tp_sta after it, res_code=4; STALL → res_code=2.
- rst asserted mid-DATA packet → next cycle tp_sta=0, cmd_ready=1, res_valid=0; a new command then runs normally.

Source files
------------

// File: rtl/usbfs_host_transaction.sv
// USB FS host transaction initiator: sends token (+DATAx), waits for the reply, ACKs good IN data and reports one result.
// All outputs registered; tp_byte answers a byte request on the next cycle; cmd_ready is low (commands dropped) while busy.
module usbfs_host_transaction #(
  parameter int MAXPKT         = 64,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int IPG_CYCLES     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_type,
  input  logic [6:0] cmd_addr,
  input  logic [3:0] cmd_endp,
  input  logic [9:0] cmd_len,
  input  logic       cmd_toggle,
  output logic [9:0] buf_addr,
  input  logic [7:0] buf_data,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       res_valid,
  output logic [2:0] res_code,
  output logic [9:0] res_len,
  output logic       res_toggle,
  output logic       tp_sta,
  output logic [3:0] tp_pid,
  input  logic       tp_byte_req,
  output logic [7:0] tp_byte,
  output logic       tp_fin_n,
  input  logic       tp_done,
  input  logic [3:0] rp_pid,
  input  logic       rp_byte_en,
  input  logic [7:0] rp_byte,
  input  logic       rp_fin,
  input  logic       rp_okay
);

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  localparam logic [2:0] RC_ACK = 3'd0, RC_NAK = 3'd1, RC_STALL = 3'd2;
  localparam logic [2:0] RC_TIMEOUT = 3'd3, RC_ERR = 3'd4, RC_DATA_OK = 3'd5;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(IPG_CYCLES + 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(IPG_CYCLES - 1);
  localparam logic [9:0]    MAXLEN   = 10'(MAXPKT);

  typedef enum logic [3:0] {
    S_IDLE, S_TOK, S_GAP, S_DATA, S_WAIT_HS, S_WAIT_DATA, S_GAP_ACK, S_ACK, S_REPORT
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    ty_q, ty_d;
  logic [6:0]    addr_q, addr_d;
  logic [3:0]    endp_q, endp_d;
  logic [9:0]    len_q, len_d;
  logic          tog_q, tog_d;
  logic [1:0]    idx_q, idx_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [7:0]    dl0_q, dl0_d, dl1_q, dl1_d;
  logic [1:0]    fill_q, fill_d;
  logic [9:0]    rlen_q, rlen_d;
  logic          ovf_q, ovf_d;
  logic          rx_tog_q, rx_tog_d;
  logic          sta_q, sta_d;
  logic [3:0]    pid_q, pid_d;
  logic [7:0]    tbyte_q, tbyte_d;
  logic          fin_n_q, fin_n_d;
  logic [9:0]    baddr_q, baddr_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          res_valid_q, res_valid_d;
  logic [2:0]    res_code_q, res_code_d;
  logic [9:0]    res_len_q, res_len_d;
  logic          res_tog_q, res_tog_d;

  logic [9:0]    rlen_nx;
  logic          ovf_nx;
  logic          fin_go, fin_tog;
  logic [2:0]    fin_code;
  logic [4:0]    tok_crc;
  logic [7:0]    tok_b0, tok_b1;

  // Token CRC5 over {endp,addr}, addr[0] shifted in first, result inverted.
  function automatic logic [4:0] crc5(input logic [10:0] d);
    logic [4:0] c;
    logic       fb;
    c = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      fb = d[i] ^ c[4];
      c  = {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
    end
    return ~c;
  endfunction

  assign tok_crc = crc5({endp_q, addr_q});
  assign tok_b0  = {endp_q[0], addr_q};
  assign tok_b1  = {tok_crc[0], tok_crc[1], tok_crc[2], tok_crc[3], tok_crc[4], endp_q[3:1]};

  always_comb begin
    state_d     = state_q;
    ty_d        = ty_q;
    addr_d      = addr_q;
    endp_d      = endp_q;
    len_d       = len_q;
    tog_d       = tog_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    tmr_d       = tmr_q;
    dl0_d       = dl0_q;
    dl1_d       = dl1_q;
    fill_d      = fill_q;
    rx_tog_d    = rx_tog_q;
    sta_d       = 1'b0;
    pid_d       = pid_q;
    tbyte_d     = tbyte_q;
    fin_n_d     = fin_n_q;
    baddr_d     = baddr_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    res_valid_d = 1'b0;
    res_code_d  = res_code_q;
    res_len_d   = res_len_q;
    res_tog_d   = res_tog_q;
    fin_go      = 1'b0;
    fin_code    = RC_ERR;
    fin_tog     = 1'b0;
    rlen_nx     = rlen_q;
    ovf_nx      = ovf_q;

    // Hold back the last two bytes seen: they turn out to be the CRC16 once rp_fin arrives.
    if (state_q == S_WAIT_DATA && rp_byte_en) begin
      if (fill_q == 2'd2) begin
        if (rlen_q < MAXLEN) begin
          rd_valid_d = 1'b1;
          rd_data_d  = dl1_q;
          rlen_nx    = rlen_q + 10'd1;
        end else begin
          ovf_nx = 1'b1;
        end
      end else begin
        fill_d = fill_q + 2'd1;
      end
      dl1_d = dl0_q;
      dl0_d = rp_byte;
    end
    rlen_d = rlen_nx;
    ovf_d  = ovf_nx;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          ty_d    = cmd_type;
          addr_d  = cmd_addr;
          endp_d  = cmd_endp;
          len_d   = (cmd_len > MAXLEN) ? MAXLEN : cmd_len;
          tog_d   = cmd_toggle;
          idx_d   = 2'd0;
          baddr_d = 10'd0;
          rlen_d  = 10'd0;
          ovf_d   = 1'b0;
          fill_d  = 2'd0;
          sta_d   = 1'b1;
          pid_d   = (cmd_type == 2'd1) ? PID_IN : (cmd_type == 2'd2) ? PID_SETUP : PID_OUT;
          state_d = S_TOK;
        end
      end
      S_TOK: begin
        if (tp_byte_req) begin
          case (idx_q)
            2'd0:    begin tbyte_d = tok_b0; fin_n_d = 1'b1; end
            2'd1:    begin tbyte_d = tok_b1; fin_n_d = 1'b1; end
            default: begin tbyte_d = 8'h00;  fin_n_d = 1'b0; end
          endcase
          if (idx_q != 2'd2) idx_d = idx_q + 2'd1;
        end
        if (tp_done) begin
          if (ty_q == 2'd1) begin
            state_d = S_WAIT_DATA;
            tmr_d   = '0;
          end else begin
            state_d = S_GAP;
            gap_d   = '0;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          sta_d   = 1'b1;
          pid_d   = (ty_q == 2'd2 || !tog_q) ? PID_DATA0 : PID_DATA1;
          state_d = S_DATA;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      S_DATA: begin
        // buf_addr already points at the next byte, so buf_data is ready when the request comes.
        if (tp_byte_req) begin
          if (baddr_q < len_q) begin
            tbyte_d = buf_data;
            fin_n_d = 1'b1;
            baddr_d = baddr_q + 10'd1;
          end else begin
            fin_n_d = 1'b0;
          end
        end
        if (tp_done) begin
          state_d = S_WAIT_HS;
          tmr_d   = '0;
        end
      end
      S_WAIT_HS: begin
        if (rp_fin) begin
          fin_go = 1'b1;
          if (!rp_okay)              fin_code = RC_ERR;
          else if (rp_pid == PID_ACK)   fin_code = RC_ACK;
          else if (rp_pid == PID_NAK)   fin_code = RC_NAK;
          else if (rp_pid == PID_STALL) fin_code = RC_STALL;
          else                          fin_code = RC_ERR;
        end else if (tmr_q == TMR_LAST) begin
          fin_go   = 1'b1;
          fin_code = RC_TIMEOUT;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_WAIT_DATA: begin
        if (rp_fin) begin
          if (rp_okay && (rp_pid == PID_DATA0 || rp_pid == PID_DATA1) && !ovf_nx) begin
            rx_tog_d = rp_pid[3];
            gap_d    = '0;
            state_d  = S_GAP_ACK;
          end else begin
            fin_go = 1'b1;
            if (rp_okay && rp_pid == PID_NAK)        fin_code = RC_NAK;
            else if (rp_okay && rp_pid == PID_STALL) fin_code = RC_STALL;
            else                                     fin_code = RC_ERR;
          end
        end else if (tmr_q == TMR_LAST) begin
          fin_go   = 1'b1;
          fin_code = RC_TIMEOUT;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_GAP_ACK: begin
        if (gap_q == GAP_LAST) begin
          sta_d   = 1'b1;
          pid_d   = PID_ACK;
          state_d = S_ACK;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      S_ACK: begin
        if (tp_byte_req) begin
          tbyte_d = 8'h00;
          fin_n_d = 1'b0;
        end
        if (tp_done) begin
          fin_go   = 1'b1;
          fin_code = RC_DATA_OK;
          fin_tog  = rx_tog_q;
        end
      end
      S_REPORT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (fin_go) begin
      state_d     = S_REPORT;
      res_valid_d = 1'b1;
      res_code_d  = fin_code;
      res_len_d   = rlen_nx;
      res_tog_d   = fin_tog;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ty_q        <= 2'd0;
      addr_q      <= 7'd0;
      endp_q      <= 4'd0;
      len_q       <= 10'd0;
      tog_q       <= 1'b0;
      idx_q       <= 2'd0;
      gap_q       <= '0;
      tmr_q       <= '0;
      dl0_q       <= 8'd0;
      dl1_q       <= 8'd0;
      fill_q      <= 2'd0;
      rlen_q      <= 10'd0;
      ovf_q       <= 1'b0;
      rx_tog_q    <= 1'b0;
      sta_q       <= 1'b0;
      pid_q       <= 4'd0;
      tbyte_q     <= 8'd0;
      fin_n_q     <= 1'b0;
      baddr_q     <= 10'd0;
      rd_data_q   <= 8'd0;
      rd_valid_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_code_q  <= 3'd0;
      res_len_q   <= 10'd0;
      res_tog_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ty_q        <= ty_d;
      addr_q      <= addr_d;
      endp_q      <= endp_d;
      len_q       <= len_d;
      tog_q       <= tog_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      tmr_q       <= tmr_d;
      dl0_q       <= dl0_d;
      dl1_q       <= dl1_d;
      fill_q      <= fill_d;
      rlen_q      <= rlen_d;
      ovf_q       <= ovf_d;
      rx_tog_q    <= rx_tog_d;
      sta_q       <= sta_d;
      pid_q       <= pid_d;
      tbyte_q     <= tbyte_d;
      fin_n_q     <= fin_n_d;
      baddr_q     <= baddr_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      res_valid_q <= res_valid_d;
      res_code_q  <= res_code_d;
      res_len_q   <= res_len_d;
      res_tog_q   <= res_tog_d;
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign buf_addr   = baddr_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign res_valid  = res_valid_q;
  assign res_code   = res_code_q;
  assign res_len    = res_len_q;
  assign res_toggle = res_tog_q;
  assign tp_sta     = sta_q;
  assign tp_pid     = pid_q;
  assign tp_byte    = tbyte_q;
  assign tp_fin_n   = fin_n_q;

endmodule

// File: tb/tb_usbfs_host_transaction.sv
// Directed bench for usbfs_host_transaction: table of whole transactions plus hand-written timeout/reset sequences.
module tb_usbfs_host_transaction;

  localparam int MAXPKT = 64;
  localparam int TMO    = 1000;
  localparam int IPG    = 16;

  localparam logic [3:0] P_OUT = 4'b0001, P_IN = 4'b1001, P_SETUP = 4'b1101;
  localparam logic [3:0] P_D0 = 4'b0011, P_D1 = 4'b1011;
  localparam logic [3:0] P_ACK = 4'b0010, P_NAK = 4'b1010, P_STALL = 4'b1110;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0, cmd_ready;
  logic [1:0] cmd_type = 2'd0;
  logic [6:0] cmd_addr = 7'd0;
  logic [3:0] cmd_endp = 4'd0;
  logic [9:0] cmd_len = 10'd0;
  logic       cmd_toggle = 1'b0;
  logic [9:0] buf_addr;
  logic [7:0] buf_data = 8'd0;
  logic [7:0] rd_data;
  logic       rd_valid, res_valid, res_toggle;
  logic [2:0] res_code;
  logic [9:0] res_len;
  logic       tp_sta, tp_fin_n;
  logic [3:0] tp_pid;
  logic [7:0] tp_byte;
  logic       tp_byte_req = 1'b0, tp_done = 1'b0;
  logic [3:0] rp_pid = 4'd0;
  logic       rp_byte_en = 1'b0, rp_fin = 1'b0, rp_okay = 1'b0;
  logic [7:0] rp_byte = 8'd0;

  usbfs_host_transaction #(.MAXPKT(MAXPKT), .TIMEOUT_CYCLES(TMO), .IPG_CYCLES(IPG)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_addr(cmd_addr), .cmd_endp(cmd_endp), .cmd_len(cmd_len), .cmd_toggle(cmd_toggle),
    .buf_addr(buf_addr), .buf_data(buf_data), .rd_data(rd_data), .rd_valid(rd_valid),
    .res_valid(res_valid), .res_code(res_code), .res_len(res_len), .res_toggle(res_toggle),
    .tp_sta(tp_sta), .tp_pid(tp_pid), .tp_byte_req(tp_byte_req), .tp_byte(tp_byte),
    .tp_fin_n(tp_fin_n), .tp_done(tp_done), .rp_pid(rp_pid), .rp_byte_en(rp_byte_en),
    .rp_byte(rp_byte), .rp_fin(rp_fin), .rp_okay(rp_okay)
  );

  always #8 clk = ~clk;

  logic [7:0] mem [0:1023];
  always @(posedge clk) buf_data <= mem[buf_addr];

  int         sta_total = 0;
  int         rd_total = 0;
  logic [7:0] rd_buf [0:1023];
  always @(negedge clk) begin
    if (tp_sta) sta_total <= sta_total + 1;
    if (rd_valid) begin
      rd_buf[rd_total & 1023] <= rd_data;
      rd_total <= rd_total + 1;
    end
  end

  int checks = 0;
  int failures = 0;
  logic [7:0] txb [0:127];

  typedef struct {
    logic [1:0] ty;   logic [6:0] ad;  logic [3:0] ep;  logic [9:0] ln;  logic tg;
    logic [3:0] rpid; int rnb;         logic rdat;      logic rok;
    logic [3:0] tpid; logic [7:0] b0;  logic [7:0] b1;  logic [3:0] dpid; int dlen;
    logic [2:0] code; logic chk_len;   logic [9:0] rlen; logic rtog;
  } vec_t;

  vec_t vecs [13];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Plays the packet-TX side: waits for tp_sta, pulls bytes until tp_fin_n=0, then pulses tp_done.
  task automatic tx_packet(input int lim, output bit seen, output int n, output logic [3:0] pid, output int nb);
    n = 0;
    nb = 0;
    while (!tp_sta && n < lim) begin step(); n++; end
    seen = tp_sta;
    pid  = tp_pid;
    if (seen) begin
      for (int k = 0; k < 100; k++) begin
        tp_byte_req = 1'b1;
        step();
        tp_byte_req = 1'b0;
        if (!tp_fin_n) break;
        txb[nb] = tp_byte;
        nb++;
        step();
        step();
      end
      step();
      tp_done = 1'b1;
      step();
      tp_done = 1'b0;
    end
  endtask

  task automatic send_cmd(input vec_t v);
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin step(); n++; end
    cmd_valid = 1'b1; cmd_type = v.ty; cmd_addr = v.ad; cmd_endp = v.ep;
    cmd_len = v.ln; cmd_toggle = v.tg;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic run_vec(input int id, input vec_t v);
    bit seen;
    int n, nb, rd0, sta0, errs;
    logic [3:0] pid;
    send_cmd(v);
    tx_packet(40, seen, n, pid, nb);
    chk($sformatf("v%0d_tok_sta", id), 32'(seen), 1);
    chk($sformatf("v%0d_tok_pid", id), 32'(pid), 32'(v.tpid));
    chk($sformatf("v%0d_tok_nbytes", id), nb, 2);
    chk($sformatf("v%0d_tok_b0", id), 32'(txb[0]), 32'(v.b0));
    chk($sformatf("v%0d_tok_b1", id), 32'(txb[1]), 32'(v.b1));
    if (v.ty != 2'd1) begin
      tx_packet(40, seen, n, pid, nb);
      chk($sformatf("v%0d_data_gap", id), n, IPG);
      chk($sformatf("v%0d_data_pid", id), 32'(pid), 32'(v.dpid));
      chk($sformatf("v%0d_data_nbytes", id), nb, v.dlen);
      errs = 0;
      for (int i = 0; i < nb; i++) if (txb[i] !== mem[i]) errs++;
      chk($sformatf("v%0d_data_bytes_wrong", id), errs, 0);
    end
    step(); step(); step();
    rd0  = rd_total;
    sta0 = sta_total;
    rp_pid = v.rpid;
    if (v.rdat) begin
      for (int k = 0; k < v.rnb + 2; k++) begin
        rp_byte    = (k < v.rnb) ? 8'(32'h40 + k) : 8'(32'hC0 + k);
        rp_byte_en = 1'b1;
        step();
        rp_byte_en = 1'b0;
        step();
      end
    end
    rp_okay = v.rok;
    rp_fin  = 1'b1;
    step();
    rp_fin  = 1'b0;
    rp_okay = 1'b0;
    if (v.code == 3'd5) begin
      tx_packet(40, seen, n, pid, nb);
      chk($sformatf("v%0d_ack_gap", id), n, IPG);
      chk($sformatf("v%0d_ack_pid", id), 32'(pid), 32'(P_ACK));
      chk($sformatf("v%0d_ack_nbytes", id), nb, 0);
    end
    n = 0;
    while (!res_valid && n < 200) begin step(); n++; end
    chk($sformatf("v%0d_res_valid", id), 32'(res_valid), 1);
    chk($sformatf("v%0d_res_code", id), 32'(res_code), 32'(v.code));
    if (v.chk_len) begin
      chk($sformatf("v%0d_res_len", id), 32'(res_len), 32'(v.rlen));
      chk($sformatf("v%0d_rd_count", id), rd_total - rd0, 32'(v.rlen));
      errs = 0;
      for (int i = 0; i < int'(v.rlen); i++)
        if (rd_buf[(rd0 + i) & 1023] !== 8'(32'h40 + i)) errs++;
      chk($sformatf("v%0d_rd_bytes_wrong", id), errs, 0);
    end
    if (v.code == 3'd5) chk($sformatf("v%0d_res_toggle", id), 32'(res_toggle), 32'(v.rtog));
    else                chk($sformatf("v%0d_no_tx_after_reply", id), sta_total - sta0, 0);
    step();
    chk($sformatf("v%0d_res_pulse", id), 32'(res_valid), 0);
    step();
  endtask

  initial begin : main
    bit seen;
    int n, nb, sta0;
    logic [3:0] pid;
    vec_t tv;

    for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 3 + 7);
    //           ty    ad     ep    ln      tg    rpid     rnb rdat rok   tpid     b0     b1     dpid   dlen code  chk   rlen  rtog
    vecs[0]  = '{2'd0, 7'h15, 4'hE, 10'd0,   1'b0, P_ACK,   0,  1'b0, 1'b1, P_OUT,   8'h15, 8'hEF, P_D0, 0,  3'd0, 1'b1, 10'd0,  1'b0};
    vecs[1]  = '{2'd2, 7'h00, 4'h0, 10'd8,   1'b1, P_NAK,   0,  1'b0, 1'b1, P_SETUP, 8'h00, 8'h10, P_D0, 8,  3'd1, 1'b0, 10'd0,  1'b0};
    vecs[2]  = '{2'd1, 7'h15, 4'hE, 10'd0,   1'b0, P_D1,    4,  1'b1, 1'b1, P_IN,    8'h15, 8'hEF, P_D0, 0,  3'd5, 1'b1, 10'd4,  1'b1};
    vecs[3]  = '{2'd1, 7'h00, 4'h0, 10'd0,   1'b0, P_D0,    3,  1'b1, 1'b0, P_IN,    8'h00, 8'h10, P_D0, 0,  3'd4, 1'b0, 10'd0,  1'b0};
    vecs[4]  = '{2'd1, 7'h15, 4'hE, 10'd0,   1'b0, P_STALL, 0,  1'b0, 1'b1, P_IN,    8'h15, 8'hEF, P_D0, 0,  3'd2, 1'b1, 10'd0,  1'b0};
    vecs[5]  = '{2'd0, 7'h00, 4'h0, 10'd100, 1'b1, P_ACK,   0,  1'b0, 1'b1, P_OUT,   8'h00, 8'h10, P_D1, 64, 3'd0, 1'b0, 10'd0,  1'b0};
    vecs[6]  = '{2'd0, 7'h15, 4'hE, 10'd3,   1'b0, P_STALL, 0,  1'b0, 1'b1, P_OUT,   8'h15, 8'hEF, P_D0, 3,  3'd2, 1'b0, 10'd0,  1'b0};
    vecs[7]  = '{2'd0, 7'h00, 4'h0, 10'd1,   1'b1, P_D0,    0,  1'b0, 1'b1, P_OUT,   8'h00, 8'h10, P_D1, 1,  3'd4, 1'b0, 10'd0,  1'b0};
    vecs[8]  = '{2'd0, 7'h15, 4'hE, 10'd2,   1'b0, P_ACK,   0,  1'b0, 1'b0, P_OUT,   8'h15, 8'hEF, P_D0, 2,  3'd4, 1'b0, 10'd0,  1'b0};
    vecs[9]  = '{2'd1, 7'h00, 4'h0, 10'd0,   1'b0, P_D0,    64, 1'b1, 1'b1, P_IN,    8'h00, 8'h10, P_D0, 0,  3'd5, 1'b1, 10'd64, 1'b0};
    vecs[10] = '{2'd1, 7'h15, 4'hE, 10'd0,   1'b0, P_D1,    66, 1'b1, 1'b1, P_IN,    8'h15, 8'hEF, P_D0, 0,  3'd4, 1'b1, 10'd64, 1'b0};
    vecs[11] = '{2'd1, 7'h00, 4'h0, 10'd0,   1'b0, P_NAK,   0,  1'b0, 1'b1, P_IN,    8'h00, 8'h10, P_D0, 0,  3'd1, 1'b1, 10'd0,  1'b0};
    vecs[12] = '{2'd0, 7'h15, 4'hE, 10'd64,  1'b0, P_ACK,   0,  1'b0, 1'b1, P_OUT,   8'h15, 8'hEF, P_D0, 64, 3'd0, 1'b0, 10'd0,  1'b0};

    repeat (3) step();
    rst = 1'b0;
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_tp_sta", 32'(tp_sta), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_buf_addr", 32'(buf_addr), 0);
    chk("rst_tp_fin_n", 32'(tp_fin_n), 0);
    chk("rst_res_code", 32'(res_code), 0);

    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    // No reply at all: TIMEOUT decided TMO cycles after tp_done; a reply one cycle later is ignored.
    tv = vecs[4];
    send_cmd(tv);
    tx_packet(40, seen, n, pid, nb);
    n = 0;
    while (!res_valid && n < TMO + 100) begin step(); n++; end
    chk("tmo_res_valid", 32'(res_valid), 1);
    chk("tmo_latency", n, TMO);
    chk("tmo_code", 32'(res_code), 3);
    rp_pid = P_STALL; rp_okay = 1'b1; rp_fin = 1'b1;
    step();
    rp_fin = 1'b0; rp_okay = 1'b0;
    chk("tmo_late_reply_ignored", 32'(res_valid), 0);
    chk("tmo_back_idle", 32'(cmd_ready), 1);
    chk("tmo_code_held", 32'(res_code), 3);
    step(); step();

    // Reply on the deadline cycle itself beats the timeout.
    send_cmd(tv);
    tx_packet(40, seen, n, pid, nb);
    repeat (TMO - 1) step();
    chk("dl_no_early_result", 32'(res_valid), 0);
    rp_pid = P_STALL; rp_okay = 1'b1; rp_fin = 1'b1;
    step();
    rp_fin = 1'b0; rp_okay = 1'b0;
    chk("dl_res_valid", 32'(res_valid), 1);
    chk("dl_code_stall", 32'(res_code), 2);
    step(); step();

    // Reset in the middle of streaming an OUT payload.
    tv = vecs[0];
    tv.ln = 10'd8;
    send_cmd(tv);
    tx_packet(40, seen, n, pid, nb);
    n = 0;
    while (!tp_sta && n < 40) begin step(); n++; end
    chk("mid_data_sta", 32'(tp_sta), 1);
    for (int k = 0; k < 3; k++) begin
      tp_byte_req = 1'b1; step(); tp_byte_req = 1'b0; step(); step();
    end
    chk("mid_data_buf_addr", 32'(buf_addr), 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_tp_sta", 32'(tp_sta), 0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 1);
    chk("mid_rst_res_valid", 32'(res_valid), 0);
    chk("mid_rst_buf_addr", 32'(buf_addr), 0);
    sta0 = sta_total;
    repeat (40) step();
    chk("mid_rst_no_sta", sta_total - sta0, 0);
    run_vec(100, vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
